operand_feeder: RTL
===================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter: WIDTH, 16, width of operands and result.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles to wait for dp_done before aborting.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_data  input  WIDTH  operand word from the upstream source.
REQ-007 Port: in_valid  input  1  in_data holds a valid operand.
REQ-008 Port: in_ready  output  1  block accepts an operand this cycle.
REQ-009 Port: dp_data1  output  WIDTH  first operand to the datapath.
REQ-010 Port: dp_data2  output  WIDTH  second operand to the datapath.
REQ-011 Port: dp_start  output  1  one-cycle start pulse to the controller.
REQ-012 Port: dp_done  input  1  controller completion flag.
REQ-013 Port: dp_result  input  WIDTH  datapath result, valid while dp_done=1.
REQ-014 Port: out_data  output  WIDTH  captured result.
REQ-015 Port: out_valid  output  1  out_data/out_err valid.
REQ-016 Port: out_ready  input  1  downstream accepts the result.
REQ-017 Port: out_err  output  1  the result was produced by a timeout abort.
REQ-018 Port: busy  output  1  block is in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD_B, ISSUE, WAIT, DRAIN.
REQ-020 IDLE: in_ready=1; on in_valid=1, capture in_data into dp_data1 and go to LOAD_B.
REQ-021 LOAD_B: in_ready=1; on in_valid=1, capture in_data into dp_data2 and go to ISSUE; otherwise hold.
REQ-022 in_ready SHALL be 0 in ISSUE, WAIT and DRAIN; in_data is ignored in those states.
REQ-023 ISSUE: dp_start=1 for exactly one cycle, clear the timeout counter, and go to WAIT unconditionally.
REQ-024 dp_data1/dp_data2 SHALL remain stable from capture until the block returns to IDLE.
REQ-025 WAIT: increment the counter each cycle; when dp_done=1, capture dp_result into out_data, set out_err=0, and go to DRAIN.
REQ-026 WAIT: when the counter reaches TIMEOUT with dp_done=0, set out_data=0 and out_err=1, and go to DRAIN.
REQ-027 If dp_done=1 in the same cycle that the counter reaches TIMEOUT, dp_done SHALL win (normal completion, out_err=0).
REQ-028 dp_done asserted outside WAIT SHALL be ignored.
REQ-029 DRAIN: out_valid=1; out_data and out_err are held until out_ready=1; on out_ready=1, go to IDLE.
REQ-030 out_valid SHALL be registered and asserted the cycle after capture.
REQ-031 The minimum latency SHALL be 3 cycles, measured from the second operand accept to out_valid, when dp_done returns 1 in the first WAIT cycle.
REQ-032 The counter SHALL be wide enough to hold TIMEOUT without wrap-around.

Reset
REQ-033 When rst_n=0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-034 During reset, dp_data1, dp_data2, out_data and the counter SHALL be 0.
REQ-035 During reset, dp_start, out_valid, out_err and busy SHALL be 0, and in_ready SHALL be 1.
REQ-036 A reset asserted in any state SHALL abort the operation in progress; no dp_start or out_valid SHALL follow release without new operands.

Verification
REQ-037 Normal completion: in_data=5 then 6 accepted, dp_done with dp_result=11 after 4 WAIT cycles -> dp_data1=5, dp_data2=6, one dp_start pulse, out_data=11, out_valid=1, out_err=0.
REQ-038 Back-pressure: hold out_ready=0 for 10 cycles in DRAIN -> out_data stays 11, out_valid stays 1, in_ready stays 0; IDLE one cycle after out_ready=1.
REQ-039 Timeout: TIMEOUT=8 with dp_done never asserted -> after 8 WAIT cycles out_valid=1, out_err=1, out_data=0.
REQ-040 Simultaneous events: dp_done=1 in the same cycle the counter hits TIMEOUT, with dp_result=0x00FF -> out_data=0x00FF, out_err=0.
REQ-041 Gap and stray done: in_valid low for 5 cycles in LOAD_B, plus a dp_done pulse in IDLE -> no dp_start until the second operand arrives, and no out_valid from the stray pulse.
REQ-042 Reset mid-WAIT: drop rst_n -> all outputs return to reset values at once, and no dp_start or out_valid after release until two new operands arrive.

Source files
------------

// File: rtl/operand_feeder.sv
// -----------------------------------------------------------------------------
// operand_feeder
//
// Collects two operands from an upstream valid/ready source. It then pulses
// dp_start to a datapath controller and waits for dp_done, with a bounded
// timeout. The captured result, or an error marker, is held on a valid/ready
// output until the result is taken downstream.
//
// Parameters
//   WIDTH    operand / result width
//   TIMEOUT  maximum WAIT cycles before the operation is aborted (>= 1)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid    operand stream from upstream
//   in_ready            high in IDLE and LOAD_B (operand slots open)
//   dp_data1/dp_data2   captured operands, stable until back in IDLE
//   dp_start            one-cycle start pulse (ISSUE state)
//   dp_done/dp_result   completion flag and result from the datapath
//   out_data/out_err    captured result; out_err marks a timeout abort
//   out_valid/out_ready result handshake to downstream
//   busy                high in any state other than IDLE
// -----------------------------------------------------------------------------
module operand_feeder #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dp_data1,
  output logic [WIDTH-1:0] dp_data2,
  output logic             dp_start,
  input  logic             dp_done,
  input  logic [WIDTH-1:0] dp_result,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err,
  output logic             busy
);

  // The counter must be able to hold TIMEOUT itself, not just TIMEOUT-1.
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  // In the k-th WAIT cycle the counter holds k-1. The abort therefore fires
  // in WAIT cycle TIMEOUT, when the counter is about to reach TIMEOUT.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    dp_start   = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ISSUE;
      end
      ISSUE: begin
        dp_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (dp_done || timeout_hit) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, timeout counter and result register
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers rather than a memory. Each one is reset
  // explicitly, so a reset mid-operation leaves no stale operand or result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_data1  <= '0;
      dp_data2  <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) dp_data1 <= in_data;
        end
        LOAD_B: begin
          if (in_valid) dp_data2 <= in_data;
        end
        ISSUE: begin
          cnt <= '0;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // dp_done is checked first, so a completion in the same cycle as
          // the timeout counts as a normal result.
          if (dp_done) begin
            out_data  <= dp_result;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
          end else if (timeout_hit) begin
            out_data  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
